// File: rtl/util_fifo_sc.sv
// util_fifo_sc: single-clock FIFO with FWFT or standard read timing, optional write ack and saturating count.
// Latency: write-to-rd_valid 2 cycles (FWFT), rd_en-to-rd_data 1 cycle (standard); writes while wr_full are dropped.
module util_fifo_sc #(
    parameter int FIFO_DEPTH  = 256,
    parameter int BYTE_WIDTH  = 1,
    parameter int COUNT_WIDTH = 8,
    parameter int FWFT        = 1,
    parameter int COUNT_DELAY = 1,
    parameter int COUNT_ENA   = 1,
    parameter int DATA_ZERO   = 0,
    parameter int ACK_ENA     = 1,
    parameter     RAM_TYPE    = "block"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [BYTE_WIDTH*8-1:0]  wr_data,
    output logic                     wr_ack,
    output logic                     wr_full,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [BYTE_WIDTH*8-1:0]  rd_data,
    output logic                     rd_empty,
    output logic [COUNT_WIDTH-1:0]   data_count
);
    localparam int DW = BYTE_WIDTH * 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [63:0] CNT_MAX = (64'd1 << COUNT_WIDTH) - 64'd1;

    (* ram_style = RAM_TYPE *) logic [DW-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_next;
    logic          wr_acc;
    logic          rd_pop;
    logic          rd_adv;
    logic          out_vld;
    logic [DW-1:0] out_dat;

    assign wr_acc   = wr_en & ~wr_full;
    assign rd_valid = out_vld;
    assign rd_data  = ((DATA_ZERO != 0) && !out_vld) ? '0 : out_dat;

    // occ includes words parked in the read pipeline, so full is exact.
    always_comb begin
        occ_next = occ;
        if (wr_acc && !rd_pop) begin
            occ_next = occ + OW'(1);
        end else if (!wr_acc && rd_pop) begin
            occ_next = occ - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            wr_full <= 1'b0;
            wr_ack  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ     <= occ_next;
            wr_full <= (occ_next == OW'(FIFO_DEPTH));
            wr_ack  <= (ACK_ENA != 0) && wr_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Two-stage prefetch: RAM read register (s1) feeding the output register.
            logic [OW-1:0] mem_cnt;
            logic [DW-1:0] s1_dat;
            logic          s1_vld;
            logic          s1_load;
            logic          s2_load;

            assign rd_pop   = rd_en & out_vld;
            assign s2_load  = s1_vld & (~out_vld | rd_pop);
            assign s1_load  = (mem_cnt != '0) & (~s1_vld | s2_load);
            assign rd_adv   = s1_load;
            assign rd_empty = ~out_vld;

            always_ff @(posedge clk) begin
                if (s1_load) begin
                    s1_dat <= mem[rd_ptr];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_cnt <= '0;
                    s1_vld  <= 1'b0;
                    out_vld <= 1'b0;
                    out_dat <= '0;
                end else begin
                    mem_cnt <= mem_cnt + OW'(wr_acc) - OW'(s1_load);
                    if (s1_load) begin
                        s1_vld <= 1'b1;
                    end else if (s2_load) begin
                        s1_vld <= 1'b0;
                    end
                    if (s2_load) begin
                        out_vld <= 1'b1;
                        out_dat <= s1_dat;
                    end else if (rd_pop) begin
                        out_vld <= 1'b0;
                    end
                end
            end
        end else begin : g_std
            logic empty_q;

            assign rd_pop   = rd_en & ~empty_q;
            assign rd_adv   = rd_pop;
            assign rd_empty = empty_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    empty_q <= 1'b1;
                    out_vld <= 1'b0;
                    out_dat <= '0;
                end else begin
                    empty_q <= (occ_next == '0);
                    out_vld <= rd_pop;
                    if (rd_pop) begin
                        out_dat <= mem[rd_ptr];
                    end
                end
            end
        end

        if (COUNT_ENA == 0) begin : g_no_cnt
            assign data_count = '0;
        end else begin : g_cnt
            logic [COUNT_WIDTH-1:0] cnt_sat;

            assign cnt_sat = (64'(occ) > CNT_MAX) ? COUNT_WIDTH'(CNT_MAX) : COUNT_WIDTH'(occ);

            if (COUNT_DELAY != 0) begin : g_cnt_dly
                logic [COUNT_WIDTH-1:0] cnt_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                assign data_count = cnt_q;
            end else begin : g_cnt_now
                assign data_count = cnt_sat;
            end
        end
    endgenerate

endmodule

// File: tb/tb_util_fifo_sc.sv
// Directed bench for util_fifo_sc in its default configuration (256 x 8, FWFT, delayed count, ack on).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_util_fifo_sc;
    logic       tb_data_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       wr_full;
    logic       rd_en = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic [7:0] data_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] wdat;
    logic [7:0] rexp;
    logic       w_acc;
    int         wcnt;
    int         rcnt;
    int         bad;
    int         saw_full;
    int         saw_empty;

    always #5 tb_data_clk = ~tb_data_clk;

    util_fifo_sc dut (
        .clk        (tb_data_clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_full    (wr_full),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_empty   (rd_empty),
        .data_count (data_count)
    );

    task automatic tick();
        @(posedge tb_data_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two cycles
        tick();
        tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_data_count", data_count, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        // Five writes, FWFT latency, ack per write
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            chk("w5_ack", wr_ack, 1);
            if (i <= 2) chk("w5_not_yet_valid", rd_valid, 0);
            if (i == 3) begin
                chk("w5_first_valid", rd_valid, 1);
                chk("w5_first_data", rd_data, 8'h01);
            end
        end
        wr_en = 1'b0;
        tick();
        chk("w5_ack_off", wr_ack, 0);
        chk("w5_count", data_count, 5);
        rd_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("burst_valid", rd_valid, 1);
            chk("burst_data", rd_data, 32'(k));
            tick();
        end
        rd_en = 1'b0;
        chk("burst_end_valid", rd_valid, 0);
        chk("burst_end_empty", rd_empty, 1);
        tick();
        chk("burst_end_count", data_count, 0);

        // Fill to full, overflow attempts, pop with a concurrent write
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            if (i == 254) chk("fill_not_full_255", wr_full, 0);
            if (i == 255) begin
                chk("fill_full_256", wr_full, 1);
                chk("fill_ack_256", wr_ack, 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hEE;
            tick();
            chk("ovf_no_ack", wr_ack, 0);
            chk("ovf_still_full", wr_full, 1);
        end
        chk("full_count_sat", data_count, 255);
        chk("full_head", rd_data, 8'h00);
        wr_en = 1'b1;
        wr_data = 8'hEE;
        rd_en = 1'b1;
        tick();
        chk("full_rw_no_ack", wr_ack, 0);
        chk("full_pop_clears_full", wr_full, 0);
        chk("full_pop_next", rd_data, 8'h01);
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        bad = 0;
        rd_en = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            if (rd_valid !== 1'b1 || rd_data !== 8'(k)) bad++;
            tick();
        end
        rd_en = 1'b0;
        chk("full_drain_order", bad, 0);
        chk("full_drain_empty", rd_valid, 0);

        // Random traffic across many pointer wraps
        wdat = 8'h00;
        rexp = 8'h00;
        wcnt = 0;
        rcnt = 0;
        bad = 0;
        saw_full = 0;
        saw_empty = 0;
        wr_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            wr_en = ~wr_en;
            wr_data = wdat;
            rd_en = ($urandom_range(99) < ((c < 1500) ? 30 : 70));
            w_acc = wr_en && !wr_full;
            if (wr_full) saw_full++;
            if (c > 1500 && rd_empty) saw_empty++;
            if (rd_en && rd_valid) begin
                if (rd_data !== rexp) bad++;
                rexp++;
                rcnt++;
            end
            tick();
            if (w_acc) begin
                wdat++;
                wcnt++;
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (rd_valid) begin
                if (rd_data !== rexp) bad++;
                rexp++;
                rcnt++;
            end
            tick();
        end
        rd_en = 1'b0;
        chk("rand_order", bad, 0);
        chk("rand_all_read", rcnt, wcnt);
        chk("rand_hit_full", (saw_full != 0), 1);
        chk("rand_hit_empty", (saw_empty != 0), 1);
        chk("rand_wraps", (wcnt > 1024), 1);

        // Simultaneous read/write at occupancy 10
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        chk("occ10_count", data_count, 10);
        for (int j = 0; j < 4; j++) begin
            chk("rw_data", rd_data, 32'(8'h10 + j));
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 8'(8'h1A + j);
            tick();
            chk("rw_ack", wr_ack, 1);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        chk("rw_count_kept", data_count, 10);
        bad = 0;
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (rd_valid !== 1'b1 || rd_data !== 8'(8'h14 + k)) bad++;
            tick();
        end
        chk("rw_drain_order", bad, 0);
        for (int i = 0; i < 3; i++) begin
            chk("empty_rd_no_valid", rd_valid, 0);
            tick();
        end
        rd_en = 1'b0;
        chk("empty_rd_empty", rd_empty, 1);
        chk("hold_last_data", rd_data, 8'h1D);
        chk("empty_count", data_count, 0);

        // Reset with 100 words stored
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        chk("pre_rst_count", data_count, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_empty", rd_empty, 1);
        chk("mid_rst_full", wr_full, 0);
        chk("mid_rst_ack", wr_ack, 0);
        chk("mid_rst_count", data_count, 0);
        chk("mid_rst_data", rd_data, 0);
        wr_en = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("post_rst_ack", wr_ack, 1);
        chk("post_rst_lat1", rd_valid, 0);
        tick();
        chk("post_rst_lat2", rd_valid, 0);
        tick();
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_data", rd_data, 8'hAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/util_fifo_sc.md
Name: util_fifo_sc

Overview:
Single-clock, parameterisable FIFO with a write-enable/full interface and a read-enable/valid interface. It supports first-word-fall-through (FWFT) or standard read timing, an optional write acknowledge, and an optional occupancy count. It is the general buffering element between producer and consumer logic in one clock domain, for example DAC/ADC sample paths and UART/1553 data paths.

Parameters:
FIFO_DEPTH, 256, number of storage words; power of two, at least 4.
BYTE_WIDTH, 1, data width in bytes; data width DW = BYTE_WIDTH*8.
COUNT_WIDTH, 8, width of data_count.
FWFT, 1, 1 = first-word-fall-through read, 0 = standard read.
COUNT_DELAY, 1, 1 = data_count passes through one extra register stage.
COUNT_ENA, 1, 0 = data_count tied to 0 and count logic removed.
DATA_ZERO, 0, 1 = rd_data forced to 0 whenever rd_valid is 0.
ACK_ENA, 1, 0 = wr_ack tied to 0.
RAM_TYPE, "block", synthesis RAM style attribute ("block" or "distributed"); no functional effect.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
wr_data  in  DW  write data.
wr_ack  out  1  one-cycle pulse confirming an accepted write.
wr_full  out  1  FIFO holds FIFO_DEPTH words.
rd_en  in  1  read request / pop.
rd_valid  out  1  rd_data holds a valid word.
rd_data  out  DW  read data.
rd_empty  out  1  no word is available to the reader.
data_count  out  COUNT_WIDTH  number of stored words, saturating.

Behaviour:
- Reset: if rst=1 at a clock edge, pointers clear, contents are discarded and outputs become rd_valid=0, rd_empty=1, wr_full=0, wr_ack=0, data_count=0, rd_data=0. Reset mid-operation drops all data, including a word currently presented.
- Write acceptance: a write is accepted when wr_en=1 and wr_full=0 at the edge. The word is stored and the write pointer increments mod FIFO_DEPTH. wr_en while full is ignored, with no corruption and no ack.
- wr_ack (ACK_ENA=1): registered; 1 for exactly the cycle after each accepted write.
- wr_full: registered; 1 exactly when occupancy = FIFO_DEPTH.
- Occupancy counts every stored word, including a word held in the FWFT output register.
- FWFT=1:
  - rd_valid=1 means rd_data is the oldest word.
  - Pop: rd_en=1 with rd_valid=1. The next word, if any, appears after the following edge, allowing back-to-back pops.
  - rd_en with rd_valid=0 is ignored.
  - A word written at edge N into an empty FIFO gives rd_valid=1 after edge N+2.
  - rd_empty = ~rd_valid.
- FWFT=0:
  - A read is accepted when rd_en=1 and rd_empty=0.
  - rd_data is updated and rd_valid pulses for one cycle after that edge.
  - rd_empty is registered: 1 when occupancy is 0.
- Simultaneous read and write:
  - Both are accepted if individually legal; occupancy is unchanged.
  - When full, a pop in the same cycle does not make wr_en acceptable that cycle; the write is accepted only once wr_full is 0.
- Pointer wrap-around at FIFO_DEPTH is seamless; order is always preserved.
- DATA_ZERO=0: rd_data holds its last value while rd_valid=0. DATA_ZERO=1: rd_data=0 while rd_valid=0.
- data_count:
  - Registered occupancy, saturating at 2^COUNT_WIDTH-1 (for example, 256 words with COUNT_WIDTH=8 reads 255).
  - COUNT_DELAY=1 adds one further cycle of latency.

Test Plan:
1. Reset with rst=1 for 2 cycles -> rd_valid=0, rd_empty=1, wr_full=0, wr_ack=0, data_count=0.
2. Write 0x01..0x05 with rd_en=0 (FWFT=1) -> rd_valid=1 with rd_data=0x01 two edges after the first write; wr_ack pulses 5 times; data_count settles at 5. Then hold rd_en=1 -> 0x01..0x05 in order on consecutive cycles, then rd_valid=0.
3. Fill: write 256 incrementing bytes with no reads -> wr_full=1 after the 256th accepted write, data_count=255. Writes 257 and later are ignored with no wr_ack. Pop one word -> wr_full deasserts the next cycle.
4. Random traffic: rd_en random each cycle; wr_en toggles every cycle; the writer increments wr_data only when wr_full=0 -> the read stream is strictly incrementing mod 256 with no gaps or duplicates across many pointer wraps.
5. Simultaneous read and write at occupancy 10 -> data_count stays 10 and order is preserved. Empty-FIFO rd_en -> no rd_valid. Full-FIFO wr_en -> ignored.
6. Assert rst while holding 100 words -> all outputs return to reset values next cycle. A subsequent write of 0xAA is read back as the first word.
